// File: rtl/time_set_ctrl_pkg.sv
// time_set_ctrl_pkg: shared types, sizes and BCD-to-binary helper for the time-set controller
package time_set_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EDIT = 1'b1
    } stateT;

    localparam int NUM_DIGITS = 4;
    localparam int MAX_VALUE  = 9999;
    localparam int DATA_W     = 14;

    // d3*1000 + d2*100 + d1*10 + d0 using only shifts and adds (1000 = 1024 - 16 - 8)
    function automatic logic [DATA_W-1:0] bcdToBin(input logic [3:0] d3, input logic [3:0] d2,
                                                   input logic [3:0] d1, input logic [3:0] d0);
        logic [DATA_W-1:0] a3, a2, a1, a0;
        a3 = DATA_W'(d3);
        a2 = DATA_W'(d2);
        a1 = DATA_W'(d1);
        a0 = DATA_W'(d0);
        return (a3 << 10) - (a3 << 4) - (a3 << 3)
             + (a2 << 6) + (a2 << 5) + (a2 << 2)
             + (a1 << 3) + (a1 << 1)
             + a0;
    endfunction

endpackage

// File: rtl/time_set_ctrl_debounce.sv
// btn_debounce: synchronises a raw button, debounces it and emits one pulse per accepted press
module btn_debounce #(
    parameter int DEBOUNCE_CNT = 1_000_000
) (
    input  logic sysclk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_press
);

    localparam int CW = $clog2(DEBOUNCE_CNT + 1);

    logic [1:0]    sync;
    logic          level;
    logic          levelPrev;
    logic [CW-1:0] cnt;

    // Two-stage synchroniser, then accept a new level only after it has held for DEBOUNCE_CNT cycles
    always_ff @(posedge sysclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync      <= '0;
            level     <= 1'b0;
            levelPrev <= 1'b0;
            cnt       <= '0;
        end else begin
            sync      <= {sync[0], i_btn};
            levelPrev <= level;
            if (sync[1] != level) begin
                if (cnt == CW'(DEBOUNCE_CNT - 1)) begin
                    level <= sync[1];
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign o_press = level & ~levelPrev;

endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: button-driven four-digit BCD editor that commits a binary value on exit from edit mode
module time_set_ctrl
    import time_set_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CNT = 1_000_000
) (
    input  logic              sysclk,
    input  logic              i_rst_n,
    input  logic              i_btnMode,
    input  logic              i_btnSel,
    input  logic              i_btnInc,
    output logic [DATA_W-1:0] o_setData,
    output logic              o_setValid,
    output logic [3:0]        o_digitSel,
    output logic              o_editing
);

    logic                        modePress, selPress, incPress;
    stateT                       state, stateNext;
    logic [1:0]                  idx, idxNext;
    logic [NUM_DIGITS-1:0][3:0]  digits, digitsNext;
    logic                        commit;
    logic                        editingNext;
    logic [3:0]                  digitSelNext;
    logic [DATA_W-1:0]           setDataNext;

    btn_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) uMode (
        .sysclk (sysclk), .i_rst_n(i_rst_n), .i_btn(i_btnMode), .o_press(modePress)
    );

    btn_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) uSel (
        .sysclk (sysclk), .i_rst_n(i_rst_n), .i_btn(i_btnSel), .o_press(selPress)
    );

    btn_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) uInc (
        .sysclk (sysclk), .i_rst_n(i_rst_n), .i_btn(i_btnInc), .o_press(incPress)
    );

    // State, digit index, digits and all outputs update together
    always_ff @(posedge sysclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            digits     <= '0;
            o_setData  <= '0;
            o_setValid <= 1'b0;
            o_digitSel <= '0;
            o_editing  <= 1'b0;
        end else begin
            state      <= stateNext;
            idx        <= idxNext;
            digits     <= digitsNext;
            o_setData  <= setDataNext;
            o_setValid <= commit;
            o_digitSel <= digitSelNext;
            o_editing  <= editingNext;
        end
    end

    // Press handling with mode > sel > inc priority; only one action per cycle
    always_comb begin
        stateNext  = state;
        idxNext    = idx;
        digitsNext = digits;
        commit     = 1'b0;
        if (state == IDLE) begin
            if (modePress) begin
                stateNext = EDIT;
                idxNext   = '0;
            end
        end else if (modePress) begin
            stateNext = IDLE;
            idxNext   = '0;
            commit    = 1'b1;
        end else if (selPress) begin
            idxNext = idx + 2'd1;
        end else if (incPress) begin
            digitsNext[idx] = (digits[idx] == 4'd9) ? 4'd0 : digits[idx] + 4'd1;
        end
    end

    // Next values of the registered outputs; committed value is held between commits
    always_comb begin
        editingNext  = (stateNext == EDIT);
        digitSelNext = editingNext ? (4'd1 << idxNext) : 4'd0;
        setDataNext  = commit ? bcdToBin(digits[3], digits[2], digits[1], digits[0]) : o_setData;
    end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CNT, default 1_000_000, meaning the sysclk cycles a raw button must hold a new level before it is accepted (10 ms at 100 MHz).
REQ-002 The block SHALL have port sysclk, input, 1, the single system clock; all state is clocked on its rising edge.
REQ-003 The block SHALL have port i_rst_n, input, 1, an asynchronous active-low reset.
REQ-004 The block SHALL have port i_btnMode, input, 1, a raw asynchronous button that enters or commits edit mode.
REQ-005 The block SHALL have port i_btnSel, input, 1, a raw asynchronous button that selects the next digit.
REQ-006 The block SHALL have port i_btnInc, input, 1, a raw asynchronous button that increments the selected digit.
REQ-007 The block SHALL have port o_setData, output, 14, the committed binary value in the range 0..9999, in the same format as the display data path.
REQ-008 The block SHALL have port o_setValid, output, 1, a one-cycle strobe that is high when o_setData has just been updated.
REQ-009 The block SHALL have port o_digitSel, output, 4, a one-hot marker of the digit being edited (bit0 = ones digit), which is 0 outside edit mode.
REQ-010 The block SHALL have port o_editing, output, 1, which is high while the FSM is in the EDIT state.

Function
REQ-011 Each raw button SHALL be passed through a 2-FF synchroniser, then debounced.
REQ-012 The debounced level SHALL change only after the synchronised input differs from it for DEBOUNCE_CNT consecutive cycles; any bounce restarts the count.
REQ-013 A press SHALL be a single-cycle pulse on the debounced 0->1 transition; a held button SHALL produce exactly one pulse, and a release SHALL produce none.
REQ-014 The block SHALL hold four BCD digit registers d3..d0, each 4 bits wide, with every value kept in 0..9.
REQ-015 The FSM SHALL have two states, IDLE and EDIT.
REQ-016 In IDLE, a mode press SHALL move the FSM to EDIT with the digit index set to 0; sel and inc presses SHALL be ignored.
REQ-017 In EDIT, a sel press SHALL rotate the digit index 0->1->2->3->0.
REQ-018 In EDIT, an inc press SHALL increment the selected digit, wrapping 9->0; other digits SHALL be unchanged and there SHALL be no carry.
REQ-019 In EDIT, a mode press SHALL commit the value, return the FSM to IDLE, and clear the digit index.
REQ-020 On commit, o_setData SHALL be d3*1000 + d2*100 + d1*10 + d0, computed with shift-add logic and no divider.
REQ-021 On commit, o_setData and o_setValid SHALL be registered, so both become valid on the edge after the mode press pulse.
REQ-022 o_setValid SHALL be high for exactly one cycle per commit.
REQ-023 If press pulses from more than one button occur in the same cycle, priority SHALL be mode > sel > inc, and lower-priority pulses in that cycle SHALL be dropped.
REQ-024 Digit registers SHALL persist across commits, so re-entering EDIT shows the previously committed digits.
REQ-025 o_setData SHALL hold its value between commits.
REQ-026 o_digitSel and o_editing SHALL be registered outputs that update on the same edge as the state and index.

Reset
REQ-027 Asserting i_rst_n low SHALL immediately force all of the following to zero: state IDLE, digit index 0, d3..d0, o_setData, o_setValid, o_digitSel, o_editing, all debounce counters, and all synchroniser and debounced levels.
REQ-028 A reset asserted mid-edit SHALL discard the uncommitted digits, and no o_setValid SHALL be emitted.
REQ-029 After reset release, a button that is already held SHALL produce one press pulse once it has been stable for DEBOUNCE_CNT cycles.

Structure
REQ-030 The shared package SHALL hold the state encoding (IDLE=0, EDIT=1), the digit count (4), the maximum value (9999), and the data width (14).
REQ-031 Debounce and edge detection SHALL live in one sub-module, btn_debounce (ports sysclk, i_rst_n, i_btn, o_press, parameter DEBOUNCE_CNT), instantiated three times.
REQ-032 The top level SHALL contain only the FSM, the digit registers, and the BCD-to-binary commit logic.

Verification (DEBOUNCE_CNT=4 in simulation)
REQ-033 Reset, then one held mode press: expect o_editing=1 and o_digitSel=4'b0001 about 7 cycles later, with exactly one transition.
REQ-034 Bounce test: toggle i_btnInc every 2 cycles for 20 cycles, then hold it high: expect exactly one increment (d0 0->1).
REQ-035 Full edit sequence: enter edit, inc x2, sel, inc x3, sel, sel, inc x1, then mode: expect one o_setValid pulse with o_setData=1032 (14'h0408) and o_editing=0.
REQ-036 Wrap test: in EDIT on digit 0, apply 10 inc presses: expect d0 back to 0 and d1 unchanged.
REQ-037 Simultaneous test: force mode and inc press pulses in the same cycle while in EDIT: expect a commit and no increment.
REQ-038 Reset mid-edit: enter edit, inc x5, then pulse i_rst_n low asynchronously between clock edges: expect all outputs 0 immediately, no o_setValid, and a subsequent commit giving o_setData=0.
